// File: rtl/tug_score_keeper.sv
// Round/match scorekeeper for the tug-of-war game: saturating per-player scores, active-low
// 7-segment digits, next_round pulse after a hold, and match winner. Optional: TUG_SCORE_FLASH_EN.
module tug_score_keeper #(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 3,
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 1,
  parameter int FLASH_DIV   = 8,
  localparam int WIN_W      = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_PLAYERS-1:0]   round_win,
  output logic [7*NUM_PLAYERS-1:0] hex,
  output logic                     next_round,
  output logic                     match_over,
  output logic [WIN_W-1:0]         winner,
  output logic [1:0]               dbg_state_o
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  if (HOLD_CYCLES < 1 || FLASH_DIV < 1 || (1 << SCORE_W) <= WIN_SCORE) begin : g_param_check
    $error("tug_score_keeper: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_PULSE, S_MATCH_OVER} state_e;

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q [NUM_PLAYERS];
  logic [SCORE_W-1:0] score_d [NUM_PLAYERS];
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [WIN_W-1:0]   winner_q, winner_d;
  logic [WIN_W-1:0]   win_idx;
  logic               win_one;

  // A tie (several bits) or no bit at all counts as no decision for this round.
  always_comb begin
    win_one = (round_win != '0) && ((round_win & (round_win - 1'b1)) == '0);
    win_idx = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (round_win[i]) win_idx = WIN_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    hold_d   = hold_q;
    winner_d = winner_q;
    case (state_q)
      S_IDLE: begin
        if (win_one) begin
          if (score_q[win_idx] != SCORE_W'(WIN_SCORE))
            score_d[win_idx] = score_q[win_idx] + 1'b1;
          if (score_q[win_idx] == SCORE_W'(WIN_SCORE - 1)) begin
            state_d  = S_MATCH_OVER;
            winner_d = win_idx;
          end else begin
            state_d = S_HOLD;
            hold_d  = HOLD_W'(HOLD_CYCLES - 1);
          end
        end
      end
      S_HOLD: begin
        if (hold_q == '0) state_d = S_PULSE;
        else              hold_d  = hold_q - 1'b1;
      end
      S_PULSE:      state_d = S_IDLE;
      S_MATCH_OVER: state_d = S_MATCH_OVER;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      score_q  <= '{default: '0};
      hold_q   <= '0;
      winner_q <= '0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      hold_q   <= hold_d;
      winner_q <= winner_d;
    end
  end

  assign next_round  = (state_q == S_PULSE);
  assign match_over  = (state_q == S_MATCH_OVER);
  assign winner      = winner_q;
  assign dbg_state_o = state_q;

  function automatic logic [6:0] seg7(input logic [SCORE_W-1:0] v);
    case (int'(v))
      0:       seg7 = 7'b1000000;
      1:       seg7 = 7'b1111001;
      2:       seg7 = 7'b0100100;
      3:       seg7 = 7'b0110000;
      4:       seg7 = 7'b0011001;
      5:       seg7 = 7'b0010010;
      6:       seg7 = 7'b0000010;
      7:       seg7 = 7'b1111000;
      8:       seg7 = 7'b0000000;
      9:       seg7 = 7'b0010000;
      default: seg7 = 7'b0111111;
    endcase
  endfunction

  logic blank_win;

`ifdef TUG_SCORE_FLASH_EN
  localparam int FLASH_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
  logic               blank_q, blank_d;

  // Divider idles at zero outside MATCH_OVER so the first blink phase always shows the score.
  always_comb begin
    flash_cnt_d = '0;
    blank_d     = 1'b0;
    if (state_q == S_MATCH_OVER) begin
      if (flash_cnt_q == FLASH_W'(FLASH_DIV - 1)) begin
        flash_cnt_d = '0;
        blank_d     = ~blank_q;
      end else begin
        flash_cnt_d = flash_cnt_q + 1'b1;
        blank_d     = blank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flash_cnt_q <= '0;
      blank_q     <= 1'b0;
    end else begin
      flash_cnt_q <= flash_cnt_d;
      blank_q     <= blank_d;
    end
  end

  assign blank_win = match_over && blank_q;
`else
  assign blank_win = 1'b0;
`endif

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_digit
    assign hex[7*g +: 7] = (blank_win && winner_q == WIN_W'(g)) ? 7'b1111111 : seg7(score_q[g]);
  end

endmodule
